// File: rtl/irrigation_zone_scheduler.sv
// irrigation_zone_scheduler: round-robin zone irrigation with tank checks and a BCD mm:ss countdown.
// Define MANUAL_OVERRIDE_EN to add manual_request/manual_zone for operator-started runs.
module irrigation_zone_scheduler #(
  parameter int ZONES         = 4,
  parameter int ZONE_W        = 2,
  parameter int RUN_MINUTES   = 5,
  parameter int PAUSE_SECONDS = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              low_water_level,
  input  logic              mid_water_level,
  input  logic              high_water_level,
  input  logic [ZONES-1:0]  earth_humidity,
  input  logic              air_humidity,
  input  logic              low_temperature,
`ifdef MANUAL_OVERRIDE_EN
  input  logic              manual_request,
  input  logic [ZONE_W-1:0] manual_zone,
`endif
  output logic [ZONE_W-1:0] active_zone,
  output logic              irrigating,
  output logic [ZONES-1:0]  splinker_bomb,
  output logic [ZONES-1:0]  dripper_valvule,
  output logic              water_supply,
  output logic              alarm,
  output logic              fault,
  output logic [3:0]        minutes_d,
  output logic [3:0]        minutes_u,
  output logic [3:0]        seconds_d,
  output logic [3:0]        seconds_u
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FAULT} state_t;
  localparam logic [15:0] RUN_LOAD   = {4'(RUN_MINUTES / 10), 4'(RUN_MINUTES % 10), 8'h00};
  localparam logic [15:0] PAUSE_LOAD = {8'h00, 4'(PAUSE_SECONDS / 10), 4'(PAUSE_SECONDS % 10)};
  state_t state, state_nx;
  logic [ZONE_W-1:0] ptr, ptr_nx, zone, zone_nx, cand;
  logic mode, mode_nx, start, abort, conflict, sprinkle, expired;
  logic [15:0] bcd, bcd_nx;
  logic [ZONES-1:0] onehot;
  function automatic logic [ZONE_W-1:0] inc(input logic [ZONE_W-1:0] z);
    return (32'(z) == ZONES - 1) ? '0 : z + 1'b1;
  endfunction
  // mm:ss borrow chain; only applied to a non-zero value
  function automatic logic [15:0] dec(input logic [15:0] t);
    logic [3:0] md, mu, sd, su;
    {md, mu, sd, su} = t;
    if (su != 0) su = su - 4'd1;
    else begin
      su = 4'd9;
      if (sd != 0) sd = sd - 4'd1;
      else begin
        sd = 4'd5;
        if (mu != 0) mu = mu - 4'd1;
        else begin
          mu = 4'd9;
          md = md - 4'd1;
        end
      end
    end
    return {md, mu, sd, su};
  endfunction
  assign conflict = (high_water_level & ~mid_water_level) | (mid_water_level & ~low_water_level);
  assign sprinkle = ~air_humidity & ~low_temperature & mid_water_level;
  assign expired  = tick && bcd == 16'h0000;
`ifdef MANUAL_OVERRIDE_EN
  assign cand  = manual_request ? manual_zone : ptr;
  assign start = low_water_level & (manual_request | ~earth_humidity[ptr]);
  assign abort = (earth_humidity[zone] & ~manual_request) | ~low_water_level;
`else
  assign cand  = ptr;
  assign start = low_water_level & ~earth_humidity[ptr];
  assign abort = earth_humidity[zone] | ~low_water_level;
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      ptr          <= '0;
      zone         <= '0;
      mode         <= 1'b0;
      bcd          <= '0;
      water_supply <= 1'b0;
      alarm        <= 1'b0;
    end else begin
      state        <= state_nx;
      ptr          <= ptr_nx;
      zone         <= zone_nx;
      mode         <= mode_nx;
      bcd          <= bcd_nx;
      water_supply <= ~conflict & ~high_water_level;
      alarm        <= conflict | ~mid_water_level;
    end
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    zone_nx  = zone;
    mode_nx  = mode;
    bcd_nx   = bcd;
    if (conflict) begin
      state_nx = FAULT;
      bcd_nx   = '0;
    end else
      case (state)
        IDLE:
          if (start) begin
            state_nx = RUN;
            zone_nx  = cand;
            mode_nx  = sprinkle;
            bcd_nx   = RUN_LOAD;
          end else ptr_nx = inc(ptr);
        RUN:
          if (abort || expired) begin
            state_nx = PAUSE;
            bcd_nx   = PAUSE_LOAD;
          end else if (tick) bcd_nx = dec(bcd);
        PAUSE:
          if (expired) begin
            state_nx = IDLE;
            ptr_nx   = inc(zone);
          end else if (tick) bcd_nx = dec(bcd);
        default: state_nx = IDLE;
      endcase
  end
  assign onehot = ZONES'(1) << zone;
  always_comb begin
    irrigating      = state == RUN;
    fault           = state == FAULT;
    splinker_bomb   = (state == RUN && mode) ? onehot : '0;
    dripper_valvule = (state == RUN && !mode) ? onehot : '0;
    active_zone     = zone;
    {minutes_d, minutes_u, seconds_d, seconds_u} = bcd;
  end
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// tb_irrigation_zone_scheduler: directed checks of scheduling, BCD countdown, abort, fault and reset.
module tb_irrigation_zone_scheduler;
  logic clock = 1'b0, reset_n = 1'b0, tick = 1'b0;
  logic low = 1'b1, mid = 1'b1, high = 1'b0, air = 1'b0, temp = 1'b0;
  logic [3:0] earth = 4'b1111;
  logic [1:0] active_zone;
  logic irrigating, water_supply, alarm, fault;
  logic [3:0] splinker_bomb, dripper_valvule, minutes_d, minutes_u, seconds_d, seconds_u;
  int vectors = 0, errs = 0;
  irrigation_zone_scheduler dut (
    .clock(clock), .reset_n(reset_n), .tick(tick),
    .low_water_level(low), .mid_water_level(mid), .high_water_level(high),
    .earth_humidity(earth), .air_humidity(air), .low_temperature(temp),
    .active_zone(active_zone), .irrigating(irrigating),
    .splinker_bomb(splinker_bomb), .dripper_valvule(dripper_valvule),
    .water_supply(water_supply), .alarm(alarm), .fault(fault),
    .minutes_d(minutes_d), .minutes_u(minutes_u), .seconds_d(seconds_d), .seconds_u(seconds_u)
  );
  always #5 clock = ~clock;
  wire [15:0] bcd = {minutes_d, minutes_u, seconds_d, seconds_u};
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic ticks(input int n);
    tick = 1'b1;
    step(n);
    tick = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_run();
    int n = 0;
    while (irrigating !== 1'b1 && n < 8) begin
      step(1);
      n++;
    end
    chk("run_start", 16'(irrigating), 16'd1);
  endtask
  initial begin
    step(2);
    chk("rst_irr", 16'(irrigating), 16'd0);
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_pumps", {splinker_bomb, dripper_valvule}, 16'h0);
    chk("rst_flags", {water_supply, alarm, fault}, 16'd0);
    reset_n = 1'b1;
    step(1);
    chk("idle_wet", {irrigating, water_supply, alarm, fault}, 16'b0100);
    earth = 4'b1011;
    wait_run();
    chk("z2_zone", 16'(active_zone), 16'd2);
    chk("z2_load", bcd, 16'h0500);
    chk("z2_sprk", {splinker_bomb, dripper_valvule}, 16'b0100_0000);
    air = 1'b1;
    ticks(1);
    chk("z2_0459", bcd, 16'h0459);
    chk("z2_mode_held", {splinker_bomb, dripper_valvule}, 16'b0100_0000);
    ticks(59);
    chk("z2_0400", bcd, 16'h0400);
    ticks(180);
    chk("z2_0100", bcd, 16'h0100);
    ticks(1);
    chk("z2_0059", bcd, 16'h0059);
    ticks(59);
    chk("z2_0000", {15'(bcd), irrigating}, 16'h0001);
    ticks(1);
    chk("z2_pause", bcd, 16'h0010);
    chk("z2_pause_off", {irrigating, splinker_bomb, dripper_valvule}, 16'h0);
    earth = 4'b0110;
    ticks(10);
    chk("p_0000", {15'(bcd), irrigating}, 16'h0000);
    ticks(1);
    chk("p_idle", {irrigating, fault}, 16'd0);
    step(1);
    chk("z3_zone", {irrigating, active_zone}, 16'b111);
    chk("z3_drip", {splinker_bomb, dripper_valvule}, 16'b0000_1000);
    chk("z3_load", bcd, 16'h0500);
    ticks(301);
    chk("z3_pause", {bcd, irrigating}, {16'h0010, 1'b0});
    ticks(11);
    step(1);
    chk("wrap_z0", {irrigating, active_zone}, 16'b100);
    ticks(93);
    chk("z0_0327", bcd, 16'h0327);
    earth = 4'b0111;
    ticks(1);
    chk("abort_pause", {irrigating, bcd}, {1'b0, 16'h0010});
    ticks(11);
    wait_run();
    chk("z3b_zone", 16'(active_zone), 16'd3);
    low = 1'b0;
    step(1);
    chk("fault_flags", {fault, alarm, irrigating, water_supply}, 16'b1100);
    chk("fault_out", {splinker_bomb, dripper_valvule}, 16'h0);
    chk("fault_bcd", bcd, 16'h0000);
    low = 1'b1;
    step(1);
    chk("fault_clear", {fault, alarm, irrigating}, 16'b000);
    step(1);
    chk("ptr_kept", {irrigating, active_zone}, 16'b111);
    ticks(60);
    chk("z3b_0400", bcd, 16'h0400);
    chk("pre_rst_drip", dripper_valvule, 16'b1000);
    reset_n = 1'b0;
    #1;
    chk("async_rst", {irrigating, splinker_bomb, dripper_valvule}, 16'h0);
    chk("async_bcd", bcd, 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
